// File: rtl/fir_mac_ctrl.sv
// FIR MAC sequencer: takes one sample per frame into a circular delay line,
// then streams (coefficient, sample) pairs to the MAC for every tap.
module fir_mac_ctrl #(
  parameter int data_width = 8,
  parameter int taps       = 8,
  parameter int addr_width = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [data_width-1:0] x_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [addr_width-1:0] rom_addr,
  input  logic [data_width-1:0] rom_data,
  output logic [data_width-1:0] rom_out,
  output logic [data_width-1:0] ram_out,
  output logic                  mac_init,
  output logic                  last_pair
);

  localparam logic [addr_width-1:0] LastTap =
    addr_width'(taps - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [addr_width-1:0] r_k;
  logic [addr_width-1:0] r_wptr;
  logic [addr_width-1:0] r_newest;
  logic [addr_width-1:0] w_rd_idx;
  logic                  w_last_tap;
  logic                  w_accept;
  logic [data_width-1:0] r_delay [taps];
  logic [data_width-1:0] r_rom_out;
  logic [data_width-1:0] r_ram_out;
  logic                  r_mac_init;
  logic                  r_last_pair;

  // Power-of-two depth makes the subtraction wrap for free.
  assign w_rd_idx   = r_newest - r_k;
  assign w_last_tap = (r_k == LastTap);

  assign rom_out   = r_rom_out;
  assign ram_out   = r_ram_out;
  assign mac_init  = r_mac_init;
  assign last_pair = r_last_pair;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    ready_out = 1'b0;
    rom_addr  = '0;
    unique case (r_state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        rom_addr = r_k;
        if (w_last_tap) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_k         <= '0;
      r_wptr      <= '0;
      r_newest    <= '0;
      r_rom_out   <= '0;
      r_ram_out   <= '0;
      r_mac_init  <= 1'b0;
      r_last_pair <= 1'b0;
      for (int i = 0; i < taps; i++) r_delay[i] <= '0;
    end else begin
      if (w_accept) begin
        r_delay[r_wptr] <= x_in;
        r_newest        <= r_wptr;
        r_wptr          <= r_wptr + addr_width'(1);
        r_k             <= '0;
      end
      if (r_state == RUN) begin
        r_rom_out   <= rom_data;
        r_ram_out   <= r_delay[w_rd_idx];
        r_mac_init  <= (r_k == '0);
        r_last_pair <= w_last_tap;
        if (!w_last_tap) r_k <= r_k + addr_width'(1);
      end else begin
        // Zero pairs keep the MAC sum steady between frames.
        r_rom_out   <= '0;
        r_ram_out   <= '0;
        r_mac_init  <= 1'b0;
        r_last_pair <= 1'b0;
      end
    end
  end

endmodule
